// File: rtl/midi_pkg.sv
// Shared MIDI types, status constants and message-length helper
// for the multi-channel MIDI parser.
package midi_pkg;

    typedef logic [7:0] midi_byte_t;

    localparam midi_byte_t NoteOff         = 8'h80;
    localparam midi_byte_t NoteOn          = 8'h90;
    localparam midi_byte_t PolyPressure    = 8'hA0;
    localparam midi_byte_t ControlChange   = 8'hB0;
    localparam midi_byte_t ProgramChange   = 8'hC0;
    localparam midi_byte_t ChannelPressure = 8'hD0;
    localparam midi_byte_t PitchBend       = 8'hE0;
    localparam midi_byte_t SysExStart      = 8'hF0;
    localparam midi_byte_t MtcQf           = 8'hF1;
    localparam midi_byte_t SongPos         = 8'hF2;
    localparam midi_byte_t SongSelect      = 8'hF3;
    localparam midi_byte_t TuneReq         = 8'hF6;
    localparam midi_byte_t SysExEnd        = 8'hF7;
    localparam midi_byte_t StatusInvalid   = 8'h00;

    typedef struct packed {
        logic [1:0] len;
        midi_byte_t status;
        midi_byte_t data1;
        midi_byte_t data2;
    } midi_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_D1,
        ST_WAIT_D2,
        ST_SYSEX
    } parse_state_t;

    // 0 means the status never produces a queued message.
    function automatic logic [1:0] midi_msg_len(input midi_byte_t s);
        logic [1:0] n;
        n = 2'd0;
        if (s[7] && s[7:4] != 4'hF) begin
            n = (s[7:5] == 3'b110) ? 2'd2 : 2'd3;
        end else if (s == MtcQf || s == SongSelect) begin
            n = 2'd2;
        end else if (s == SongPos) begin
            n = 2'd3;
        end else if (s == TuneReq) begin
            n = 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// First-word-fall-through FIFO of assembled MIDI messages with
// level output and a drop strobe for writes refused at full.
module midi_msg_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      wr_i,
    input  midi_msg_t wr_data_i,
    input  logic      rd_i,
    output logic      valid_o,
    output midi_msg_t head_o,
    output logic [AW:0] level_o,
    output logic      drop_o
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    midi_msg_t r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0] r_level;

    logic w_pop;
    logic w_push;

    assign w_pop  = rd_i && (r_level != '0);
    // A pop in the same cycle frees the slot the write lands in.
    assign w_push = wr_i && ((r_level != FULL) || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    assign valid_o = (r_level != '0);
    assign head_o  = r_mem[r_rptr];
    assign level_o = r_level;
    assign drop_o  = wr_i && !w_push;

endmodule

// File: rtl/midi_parser_mc.sv
// MIDI byte parser: running status, per-channel mask, SysEx passthrough,
// real-time strobes and a ready/valid message FIFO with overflow count.
module midi_parser_mc
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int OVF_CNT_W     = 8,
    parameter bit NOTE_OFF_NORM = 1'b1,
    parameter bit SYSEX_PASS    = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          byte_valid_i,
    input  logic [7:0]                    midi_byte_i,
    input  logic [15:0]                   chan_mask_i,
    output logic                          msg_valid_o,
    input  logic                          msg_ready_i,
    output logic [1:0]                    msg_len_o,
    output logic [7:0]                    msg_status_o,
    output logic [7:0]                    msg_data1_o,
    output logic [7:0]                    msg_data2_o,
    output logic                          rt_valid_o,
    output logic [7:0]                    rt_msg_o,
    output logic                          sysex_valid_o,
    output logic [7:0]                    sysex_data_o,
    output logic                          sysex_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [OVF_CNT_W-1:0]          ovf_cnt_o
);

    parse_state_t r_state;
    midi_byte_t r_status;
    midi_byte_t r_data1;
    logic r_pend_vld;
    midi_msg_t r_pend;
    logic r_rt_valid;
    midi_byte_t r_rt_msg;
    logic r_sx_valid;
    logic r_sx_last;
    midi_byte_t r_sx_data;
    logic [OVF_CNT_W-1:0] r_ovf;

    midi_byte_t w_b;
    logic w_rt, w_in_sx, w_sx_data, w_sx_end, w_status, w_data;
    logic [1:0] w_len, w_cur_len;
    logic w_done, w_chan, w_accept;
    midi_msg_t w_msg;
    logic w_fifo_valid, w_drop;
    midi_msg_t w_head;

    assign w_b       = midi_byte_i;
    assign w_rt      = &w_b[7:3];
    assign w_in_sx   = (r_state == ST_SYSEX);
    assign w_sx_data = w_in_sx && !w_b[7];
    assign w_sx_end  = w_in_sx && (w_b == SysExEnd);
    assign w_status  = w_b[7] && !w_rt && !w_sx_end;
    assign w_data    = !w_b[7] && !w_in_sx;
    assign w_len     = midi_msg_len(w_b);
    assign w_cur_len = midi_msg_len(r_status);
    assign w_chan    = (r_status[7:4] != 4'hF);
    assign w_accept  = !w_chan || chan_mask_i[r_status[3:0]];
    assign w_done    = (r_state == ST_WAIT_D2) ||
                       (r_state == ST_WAIT_D1 && w_cur_len == 2'd2);

    always_comb begin
        w_msg = '0;
        w_msg.status = r_status;
        if (r_state == ST_WAIT_D2) begin
            w_msg.len   = 2'd3;
            w_msg.data1 = r_data1;
            w_msg.data2 = w_b;
            if (NOTE_OFF_NORM && r_status[7:4] == 4'h9 && w_b == 8'h00) begin
                w_msg.status = {4'h8, r_status[3:0]};
                w_msg.data2  = 8'h40;
            end
        end else begin
            w_msg.len   = 2'd2;
            w_msg.data1 = w_b;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_status   <= StatusInvalid;
            r_data1    <= '0;
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
            r_rt_valid <= 1'b0;
            r_rt_msg   <= '0;
            r_sx_valid <= 1'b0;
            r_sx_last  <= 1'b0;
            r_sx_data  <= '0;
        end else begin
            r_rt_valid <= 1'b0;
            r_sx_valid <= 1'b0;
            r_sx_last  <= 1'b0;
            r_pend_vld <= 1'b0;
            if (byte_valid_i) begin
                unique case (1'b1)
                    w_rt: begin
                        r_rt_valid <= 1'b1;
                        r_rt_msg   <= w_b;
                    end
                    w_sx_data: begin
                        r_sx_valid <= SYSEX_PASS;
                        r_sx_data  <= w_b;
                    end
                    w_sx_end: begin
                        r_sx_valid <= SYSEX_PASS;
                        r_sx_data  <= w_b;
                        r_sx_last  <= SYSEX_PASS;
                        r_state    <= ST_IDLE;
                    end
                    w_status: begin
                        r_state  <= ST_IDLE;
                        r_status <= StatusInvalid;
                        // Close an open SysEx with a synthetic EOX.
                        if (w_in_sx) begin
                            r_sx_valid <= SYSEX_PASS;
                            r_sx_data  <= SysExEnd;
                            r_sx_last  <= SYSEX_PASS;
                        end
                        if (w_b == SysExStart) begin
                            r_state    <= ST_SYSEX;
                            r_sx_valid <= SYSEX_PASS;
                            r_sx_data  <= w_b;
                            r_sx_last  <= 1'b0;
                        end else if (w_len == 2'd1) begin
                            r_pend_vld <= 1'b1;
                            r_pend     <= '{len: 2'd1, status: w_b,
                                            data1: 8'h00, data2: 8'h00};
                        end else if (w_len != 2'd0) begin
                            r_state  <= ST_WAIT_D1;
                            r_status <= w_b;
                        end
                    end
                    w_data: begin
                        if (w_done) begin
                            r_pend_vld <= w_accept;
                            r_pend     <= w_msg;
                            if (w_chan) begin
                                r_state <= ST_WAIT_D1;
                            end else begin
                                r_state  <= ST_IDLE;
                                r_status <= StatusInvalid;
                            end
                        end else if (r_state == ST_WAIT_D1) begin
                            r_data1 <= w_b;
                            r_state <= ST_WAIT_D2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= '0;
        end else if (w_drop && r_ovf != {OVF_CNT_W{1'b1}}) begin
            r_ovf <= r_ovf + OVF_CNT_W'(1);
        end
    end

    midi_msg_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (r_pend_vld),
        .wr_data_i (r_pend),
        .rd_i      (msg_ready_i),
        .valid_o   (w_fifo_valid),
        .head_o    (w_head),
        .level_o   (fifo_level_o),
        .drop_o    (w_drop)
    );

    assign msg_valid_o   = w_fifo_valid;
    assign msg_len_o     = w_fifo_valid ? w_head.len    : 2'd0;
    assign msg_status_o  = w_fifo_valid ? w_head.status : 8'h00;
    assign msg_data1_o   = w_fifo_valid ? w_head.data1  : 8'h00;
    assign msg_data2_o   = w_fifo_valid ? w_head.data2  : 8'h00;
    assign rt_valid_o    = r_rt_valid;
    assign rt_msg_o      = r_rt_msg;
    assign sysex_valid_o = r_sx_valid;
    assign sysex_data_o  = r_sx_data;
    assign sysex_last_o  = r_sx_last;
    assign ovf_cnt_o     = r_ovf;

endmodule

// File: tb/tb_midi_parser_mc.sv
// Scoreboard bench for midi_parser_mc: directed scenarios plus a
// random byte stream checked against a message-level reference model.
module tb_midi_parser_mc;

    localparam int DEPTH = 4;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [1:0] len;
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        int at;
    } exp_msg_t;
    typedef struct {
        logic [7:0] d;
        logic last;
        int at;
    } exp_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic byte_valid = 1'b0;
    logic [7:0] midi_byte = 8'h00;
    logic [15:0] chan_mask = 16'hFFFF;
    logic msg_ready = 1'b1;

    logic msg_valid_o;
    logic [1:0] msg_len_o;
    logic [7:0] msg_status_o, msg_data1_o, msg_data2_o;
    logic rt_valid_o;
    logic [7:0] rt_msg_o;
    logic sysex_valid_o;
    logic [7:0] sysex_data_o;
    logic sysex_last_o;
    logic [LW-1:0] fifo_level_o;
    logic [7:0] ovf_cnt_o;

    midi_parser_mc #(
        .FIFO_DEPTH(DEPTH),
        .OVF_CNT_W(8),
        .NOTE_OFF_NORM(1'b1),
        .SYSEX_PASS(1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .byte_valid_i (byte_valid),
        .midi_byte_i  (midi_byte),
        .chan_mask_i  (chan_mask),
        .msg_valid_o  (msg_valid_o),
        .msg_ready_i  (msg_ready),
        .msg_len_o    (msg_len_o),
        .msg_status_o (msg_status_o),
        .msg_data1_o  (msg_data1_o),
        .msg_data2_o  (msg_data2_o),
        .rt_valid_o   (rt_valid_o),
        .rt_msg_o     (rt_msg_o),
        .sysex_valid_o(sysex_valid_o),
        .sysex_data_o (sysex_data_o),
        .sysex_last_o (sysex_last_o),
        .fifo_level_o (fifo_level_o),
        .ovf_cnt_o    (ovf_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_msg_t q_msg[$];
    exp_ev_t q_rt[$];
    exp_ev_t q_sx[$];

    logic [7:0] m_stat;
    logic [7:0] m_data[$];
    bit m_sx;
    bit hold_mode;
    bit chk_lat;
    int m_ovf;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected output at cycle %0d", nm, cyc);
    endtask

    function automatic void push_msg(input int n, input logic [7:0] st,
                                     input logic [7:0] d1,
                                     input logic [7:0] d2, input int k);
        exp_msg_t e;
        if (st[7:4] == 4'h9 && n == 3 && d2 == 8'h00) begin
            st = {4'h8, st[3:0]};
            d2 = 8'h40;
        end
        if (hold_mode && q_msg.size() >= DEPTH) begin
            m_ovf++;
            return;
        end
        e = '{2'(n), st, d1, d2, k + 1};
        q_msg.push_back(e);
    endfunction

    // Byte k is the edge that samples it.
    function automatic void model_byte(input logic [7:0] b, input int k);
        int need;
        logic [7:0] d1, d2;
        if (b >= 8'hF8) begin
            q_rt.push_back('{b, 1'b0, k});
            return;
        end
        if (m_sx) begin
            if (b < 8'h80) begin
                q_sx.push_back('{b, 1'b0, k});
                return;
            end
            q_sx.push_back('{8'hF7, 1'b1, k});
            m_sx = 1'b0;
            if (b == 8'hF7) return;
        end
        if (b >= 8'h80) begin
            m_data.delete();
            m_stat = 8'h00;
            if (b == 8'hF0) begin
                m_sx = 1'b1;
                q_sx.push_back('{b, 1'b0, k});
            end else if (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) begin
                m_stat = b;
            end else if (b == 8'hF6) begin
                push_msg(1, b, 8'h00, 8'h00, k);
            end
            return;
        end
        if (m_stat == 8'h00) return;
        m_data.push_back(b);
        need = ((m_stat >= 8'hC0 && m_stat < 8'hE0) ||
                m_stat == 8'hF1 || m_stat == 8'hF3) ? 1 : 2;
        if (m_data.size() < need) return;
        d1 = m_data[0];
        d2 = (need == 2) ? m_data[1] : 8'h00;
        m_data.delete();
        if (m_stat < 8'hF0) begin
            if (chan_mask[m_stat[3:0]]) push_msg(need + 1, m_stat, d1, d2, k);
        end else begin
            push_msg(need + 1, m_stat, d1, d2, k);
            m_stat = 8'h00;
        end
    endfunction

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #2;
        byte_valid = 1'b1;
        midi_byte = b;
        model_byte(b, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            byte_valid = 1'b0;
            midi_byte = 8'h00;
        end
    endtask

    task automatic send_list(input bq_t l);
        foreach (l[i]) send(l[i]);
        idle(1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60 && (q_msg.size() + q_rt.size() + q_sx.size()) != 0; i++)
            @(negedge clk);
        idle(3);
        chk({nm, "_msgq"}, q_msg.size(), 0);
        chk({nm, "_evq"}, q_rt.size() + q_sx.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        byte_valid = 1'b0;
        midi_byte = 8'h00;
        m_stat = 8'h00;
        m_data.delete();
        m_sx = 1'b0;
        m_ovf = 0;
        q_msg.delete();
        q_rt.delete();
        q_sx.delete();
        @(posedge clk);
        @(negedge clk);
        chk("reset_msg", {msg_valid_o, msg_len_o, msg_status_o, msg_data1_o,
                          msg_data2_o, fifo_level_o, ovf_cnt_o}, 64'h0);
        chk("reset_ev", {rt_valid_o, rt_msg_o, sysex_valid_o, sysex_data_o,
                         sysex_last_o}, 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    exp_msg_t em;
    always @(negedge clk) begin
        if (!rst && msg_valid_o && msg_ready) begin
            if (q_msg.size() == 0) begin
                unexp("msg");
            end else begin
                em = q_msg.pop_front();
                chk("msg", {msg_len_o, msg_status_o, msg_data1_o, msg_data2_o},
                    {em.len, em.st, em.d1, em.d2});
                if (chk_lat) chk("msg_time", cyc, em.at);
            end
        end
    end

    exp_ev_t er;
    always @(negedge clk) begin
        if (!rst && rt_valid_o) begin
            if (q_rt.size() == 0) begin
                unexp("rt");
            end else begin
                er = q_rt.pop_front();
                chk("rt_msg", rt_msg_o, er.d);
                chk("rt_time", cyc, er.at);
            end
        end
    end

    exp_ev_t es;
    always @(negedge clk) begin
        if (!rst && sysex_valid_o) begin
            if (q_sx.size() == 0) begin
                unexp("sysex");
            end else begin
                es = q_sx.pop_front();
                chk("sysex", {sysex_data_o, sysex_last_o}, {es.d, es.last});
                chk("sysex_time", cyc, es.at);
            end
        end
    end

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55) return 8'($urandom_range(0, 127));
        if (r < 70) return 8'($urandom_range(128, 239));
        if (r < 80) return 8'($urandom_range(248, 255));
        if (r < 92) return 8'($urandom_range(241, 247));
        return m_sx ? 8'h05 : 8'hF0;
    endfunction

    bq_t seq;

    initial begin
        hold_mode = 1'b0;
        chk_lat = 1'b1;
        do_reset();

        chan_mask = 16'hFFFF;
        seq = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h00};
        send_list(seq);
        drain("norm");

        chan_mask = 16'h0002;
        seq = '{8'h90, 8'h40, 8'h7F, 8'h91, 8'h40, 8'h7F, 8'hC1, 8'h05};
        send_list(seq);
        drain("mask");
        chk("mask_ovf", ovf_cnt_o, 0);

        chan_mask = 16'hFFFF;
        seq = '{8'h90, 8'h3C, 8'hF8, 8'h64};
        send_list(seq);
        drain("rt");

        seq = '{8'hF0, 8'h43, 8'h10, 8'hF7, 8'hF0, 8'h43, 8'h90, 8'h3C, 8'h64};
        send_list(seq);
        drain("sysex");

        seq = '{8'hF2, 8'h10, 8'h20, 8'hF3, 8'h05, 8'h22, 8'hF6, 8'hF5, 8'h11};
        send_list(seq);
        drain("syscom");

        send(8'h90);
        send(8'h3C);
        do_reset();
        seq = '{8'h40, 8'h7F};
        send_list(seq);
        drain("midrst");

        do_reset();
        msg_ready = 1'b0;
        chk_lat = 1'b0;
        hold_mode = 1'b1;
        for (int n = 0; n < 6; n++) begin
            send(8'hC0);
            send(8'(n));
        end
        idle(4);
        chk("full_level", fifo_level_o, 4);
        chk("full_ovf", ovf_cnt_o, 2);
        chk("model_ovf", m_ovf, 2);
        hold_mode = 1'b0;
        send(8'hC0);
        send(8'h07);
        @(posedge clk);
        #2;
        byte_valid = 1'b0;
        msg_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("popwr_level", fifo_level_o, 4);
        chk("popwr_ovf", ovf_cnt_o, 2);
        drain("full");
        chk("empty_level", fifo_level_o, 0);

        do_reset();
        chk_lat = 1'b1;
        msg_ready = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if (i % 64 == 0) chan_mask = 16'($urandom);
            send(rnd_byte());
            idle($urandom_range(0, 2));
        end
        idle(1);
        drain("rand");
        chk("rand_ovf", ovf_cnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/midi_parser_mc.md
Name: midi_parser_mc

Overview:
- Parametrised successor to the single-channel MIDI parser: classifies UART-received MIDI bytes, tracks running status, and assembles channel-voice and system-common messages.
- Channel selection is a 16-bit per-channel mask instead of a single channel/OMNI value.
- Adds an optional Note-On velocity-0 to Note-Off normalisation, SysEx byte passthrough, and a ready/valid message FIFO with overflow accounting.
- Sits between the MIDI UART RX and the MMIO register/IRQ layer.

Parameters:
FIFO_DEPTH, 8, message FIFO entries; power of 2, >=2
OVF_CNT_W, 8, width of saturating overflow counter
NOTE_OFF_NORM, 1, 1 = Note-On (9n) with velocity 0 emitted as Note-Off (8n) with velocity 0x40
SYSEX_PASS, 1, 1 = forward SysEx bytes on sysex_* port; 0 = drain silently

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
byte_valid_i  in  1  one-cycle strobe, midi_byte_i valid
midi_byte_i  in  8  received byte
chan_mask_i  in  16  bit n=1 accepts channel-voice messages on channel n (0-based)
msg_valid_o  out  1  FIFO head valid
msg_ready_i  in  1  consumer pops head when msg_valid_o && msg_ready_i
msg_len_o  out  2  1..3 bytes
msg_status_o  out  8  status byte
msg_data1_o  out  8  data 1 (0 if len<2)
msg_data2_o  out  8  data 2 (0 if len<3)
rt_valid_o  out  1  one-cycle real-time strobe
rt_msg_o  out  8  real-time byte (F8-FF)
sysex_valid_o  out  1  one-cycle strobe per SysEx byte
sysex_data_o  out  8  SysEx byte, including F0 and F7
sysex_last_o  out  1  with sysex_valid_o: this byte is F7 or an aborting status
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
ovf_cnt_o  out  OVF_CNT_W  dropped messages, saturating

Behaviour:
- Reset (rst_i high at an edge):
  - All outputs 0.
  - Running status = invalid (00); pending-byte flags cleared; sysex state cleared.
  - FIFO emptied; ovf_cnt_o = 0.
  - Reset mid-message discards partial state.
- Byte handling:
  - Real-time F8-FF: rt_valid_o/rt_msg_o registered on the edge after the strobe (latency 1). No effect on running status, pending data or SysEx, even mid-message.
  - F0: running status -> invalid; enter SYSEX state. With SYSEX_PASS=1, F0 and every following non-RT byte are emitted on sysex_* (latency 1).
  - SYSEX state, byte F7: emitted with sysex_last_o=1; return to IDLE.
  - SYSEX state, other status byte (F1-F6, 80-EF): emit a sysex_last_o=1 strobe with sysex_data_o=F7, then process that byte as a normal status byte in the same cycle.
- Parser states:
  - IDLE: no data pending. Any data byte with invalid running status is discarded.
  - WAIT_D1: status held, expecting data 1.
  - WAIT_D2: data 1 held, expecting data 2.
  - SYSEX: as above.
- Status bytes and running status:
  - A status byte always aborts any partial message. The partial message is discarded and never enqueued.
  - Lengths: 8n/9n/An/Bn/En = 3. Cn/Dn = 2. F1, F3 = 2. F2 = 3. F6 = 1. F4/F5/F7 = 1 but discarded (undefined / stray EOX).
  - A 1-byte message is enqueued immediately.
  - Channel-voice status sets running status. After completion, return to WAIT_D1 with running status retained.
  - System-common status clears running status after completion.
- Channel filter:
  - Applied when a channel-voice message completes. The message is enqueued only if chan_mask_i[status[3:0]] is 1.
  - The mask is sampled at completion time.
  - The filter affects only the enqueue; parser state advances identically whether or not the channel is accepted.
- Normalisation: when NOTE_OFF_NORM=1, status 9n with data2=0 is enqueued as 8n, data1 unchanged, data2=40.
- FIFO timing:
  - A completed message is registered into the pending-write slot on the edge that samples its last byte (edge k).
  - It is written to the FIFO at edge k+1.
  - msg_valid_o is high after edge k+1 if the FIFO was empty. Latency 2 from the last byte.
  - The FIFO is first-word-fall-through; outputs are the head entry.
- Full / simultaneous events:
  - If full at the write edge and no pop occurs that cycle, the message is dropped and ovf_cnt_o increments, saturating at all-ones.
  - A pop and a write in the same cycle at full: both succeed and the level is unchanged.
  - A pop and a write at empty: the write succeeds and the level goes to 1.
  - The byte rate is at most one message per cycle, so one pending slot is sufficient.
- Output stability: outputs hold while msg_valid_o && !msg_ready_i.

Decomposition:
- midi_pkg (shared):
  - midi_byte_t.
  - Status constants: NoteOff 80, NoteOn 90, PolyPressure A0, ControlChange B0, ProgramChange C0, ChannelPressure D0, PitchBend E0, SysExStart F0, MtcQf F1, SongPos F2, SongSelect F3, TuneReq F6, SysExEnd F7, StatusInvalid 00.
  - midi_msg_t packed struct {len[1:0], status, data1, data2}.
  - Function midi_msg_len(status) returning 0..3.
- Sub-module midi_msg_fifo: parametrised FWFT FIFO of midi_msg_t with level output.

Test Plan:
- Reset, then bytes 90 3C 64 3C 00 with mask FFFF, NOTE_OFF_NORM=1 -> two messages, each after 2 cycles: {3,90,3C,64} and {3,80,3C,40}. Running status is reused for the second.
- mask 0002; bytes 90 40 7F, 91 40 7F, C1 05 -> only {3,91,40,7F} and {2,C1,05,00} enqueued; ovf_cnt_o stays 0.
- Bytes 90 3C F8 64 -> rt_valid_o pulse with F8 one cycle after the F8 strobe; message {3,90,3C,64} still completes.
- Bytes F0 43 10 F7 with SYSEX_PASS=1 -> four sysex_valid_o strobes carrying F0,43,10,F7, sysex_last_o only on F7, no FIFO entry. Then F0 43 90 3C 64 -> sysex_last_o strobe with data F7, then {3,90,3C,64}.
- Bytes F2 10 20, F3 05, 22 -> {3,F2,10,20} and {2,F3,05,00}; trailing 22 discarded because running status is invalid.
- FIFO_DEPTH=4, msg_ready_i=0, six C0 0n messages -> fifo_level_o=4, ovf_cnt_o=2. Then hold msg_ready_i=1 while a new message writes at full -> level stays 4 and the oldest entry is popped first.
